// File: rtl/dcache_flush_seq.sv
// Flush sequencer: walks every set/way of the tag array, writes back dirty lines and then cleans
// or invalidates them. Optional write-back perf counter enabled by DCACHE_FLUSH_PERF_EN.
module dcache_flush_seq #(
   parameter int unsigned NumSets           = 256,
   parameter int unsigned NumWays           = 8,
   parameter bit          InvalidateOnFlush = 1'b1,
   parameter int unsigned IdxW              = $clog2(NumSets),
   parameter int unsigned WayW              = $clog2(NumWays)
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            flush_req_i,
   output logic            flush_ack_o,
   output logic            busy_o,
   output logic            tag_req_o,
   output logic            tag_we_o,
   output logic [IdxW-1:0] tag_idx_o,
   output logic [WayW-1:0] tag_way_o,
   output logic            tag_wvalid_o,
   output logic            tag_wdirty_o,
   input  logic            tag_gnt_i,
   input  logic            tag_rvalid_i,
   input  logic            tag_valid_i,
   input  logic            tag_dirty_i,
   output logic            wb_req_o,
   input  logic            wb_gnt_i,
   input  logic            wb_done_i,
   output logic [15:0]     perf_wb_cnt_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_RWAIT,
      S_WB,
      S_WBWAIT,
      S_UPD,
      S_DONE
   } state_e;

   localparam logic [IdxW-1:0] LastIdx = IdxW'(NumSets - 1);
   localparam logic [WayW-1:0] LastWay = WayW'(NumWays - 1);

   state_e          state_q, state_d;
   logic [IdxW-1:0] idx_q, idx_d;
   logic [WayW-1:0] way_q, way_d;
   logic            tag_req_q, tag_req_d;
   logic            tag_we_q, tag_we_d;
   logic            tag_wvalid_q, tag_wvalid_d;
   logic            wb_req_q, wb_req_d;
   logic            ack_q, ack_d;
   logic            busy_q, busy_d;
   logic            last_line;
   logic            step;

   assign last_line = (idx_q == LastIdx) && (way_q == LastWay);

   // Next state and counters; "step" is the advance-to-next-line transition shared by RWAIT and UPD.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      way_d   = way_q;
      step    = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (flush_req_i) begin
               idx_d   = '0;
               way_d   = '0;
               state_d = S_RD;
            end
         end
         S_RD: begin
            if (tag_gnt_i) begin
               state_d = S_RWAIT;
            end
         end
         S_RWAIT: begin
            if (tag_rvalid_i) begin
               if (!tag_valid_i) begin
                  step = 1'b1;
               end else if (tag_dirty_i) begin
                  state_d = S_WB;
               end else if (InvalidateOnFlush) begin
                  state_d = S_UPD;
               end else begin
                  step = 1'b1;
               end
            end
         end
         S_WB: begin
            if (wb_gnt_i) begin
               state_d = S_WBWAIT;
            end
         end
         S_WBWAIT: begin
            if (wb_done_i) begin
               state_d = S_UPD;
            end
         end
         S_UPD: begin
            if (tag_gnt_i) begin
               step = 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (step) begin
         if (last_line) begin
            state_d = S_DONE;
         end else begin
            state_d = S_RD;
            way_d   = way_q + 1'b1;
            if (way_q == LastWay) begin
               idx_d = idx_q + 1'b1;
            end
         end
      end
   end

   // Outputs are decoded from the next state so they are registered yet line up with the state.
   always_comb begin
      tag_req_d    = (state_d == S_RD) || (state_d == S_UPD);
      tag_we_d     = (state_d == S_UPD);
      tag_wvalid_d = (state_d == S_UPD) && !InvalidateOnFlush;
      wb_req_d     = (state_d == S_WB);
      ack_d        = (state_d == S_DONE);
      busy_d       = (state_d != S_IDLE);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= S_IDLE;
         idx_q        <= '0;
         way_q        <= '0;
         tag_req_q    <= 1'b0;
         tag_we_q     <= 1'b0;
         tag_wvalid_q <= 1'b0;
         wb_req_q     <= 1'b0;
         ack_q        <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         way_q        <= way_d;
         tag_req_q    <= tag_req_d;
         tag_we_q     <= tag_we_d;
         tag_wvalid_q <= tag_wvalid_d;
         wb_req_q     <= wb_req_d;
         ack_q        <= ack_d;
         busy_q       <= busy_d;
      end
   end

   assign flush_ack_o  = ack_q;
   assign busy_o       = busy_q;
   assign tag_req_o    = tag_req_q;
   assign tag_we_o     = tag_we_q;
   assign tag_idx_o    = idx_q;
   assign tag_way_o    = way_q;
   assign tag_wvalid_o = tag_wvalid_q;
   assign tag_wdirty_o = 1'b0;
   assign wb_req_o     = wb_req_q;

`ifdef DCACHE_FLUSH_PERF_EN
   logic [15:0] perf_q, perf_d;

   // Saturating count of completed write-backs, restarted at the beginning of each pass.
   always_comb begin
      perf_d = perf_q;
      if ((state_q == S_IDLE) && flush_req_i) begin
         perf_d = '0;
      end else if ((state_q == S_WBWAIT) && wb_done_i && (perf_q != 16'hFFFF)) begin
         perf_d = perf_q + 16'd1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         perf_q <= '0;
      end else begin
         perf_q <= perf_d;
      end
   end

   assign perf_wb_cnt_o = perf_q;
`else
   assign perf_wb_cnt_o = 16'h0000;
`endif

   a_one_port: assert property (@(posedge clk_i) disable iff (!rst_ni) !(tag_req_o && wb_req_o));
   a_ack_pulse: assert property (@(posedge clk_i) disable iff (!rst_ni) flush_ack_o |=> !flush_ack_o);

endmodule

// File: tb/tb_dcache_flush_seq.sv
// Randomized bench for dcache_flush_seq: three configurations (4x2 invalidate, 4x2 clean, 2x2
// invalidate) share one cache responder; a line-level model predicts reads, write-backs, writes, timing.
module tb_dcache_flush_seq;

   logic clk = 1'b0;
   logic rst_ni = 1'b1;
   logic flush_req = 1'b0;
   logic tag_gnt = 1'b0;
   logic tag_rvalid = 1'b0;
   logic tag_valid = 1'b0;
   logic tag_dirty = 1'b0;
   logic wb_gnt = 1'b0;
   logic wb_done = 1'b0;
   logic [1:0] sel = 2'd0;

   logic [2:0] ack, busy, treq, twe, twv, twd, wbr, tway;
   logic [1:0] tidx0, tidx1;
   logic [0:0] tidx2;
   logic [15:0] perf0, perf1, perf2;

   logic o_ack, o_busy, o_req, o_we, o_wvalid, o_wdirty, o_wb_req, o_way;
   logic [1:0] o_idx;
   logic [15:0] o_perf;

   // cache tag state seen by the responder, one entry per line (line = idx*2 + way)
   logic mv [8];
   logic md [8];
   int rd_q[$];
   int wr_q[$];
   int wb_q[$];

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   dcache_flush_seq #(.NumSets(4), .NumWays(2), .InvalidateOnFlush(1'b1)) dut0 (
      .clk_i(clk), .rst_ni(rst_ni), .flush_req_i(flush_req && (sel == 2'd0)),
      .flush_ack_o(ack[0]), .busy_o(busy[0]), .tag_req_o(treq[0]), .tag_we_o(twe[0]),
      .tag_idx_o(tidx0), .tag_way_o(tway[0:0]), .tag_wvalid_o(twv[0]), .tag_wdirty_o(twd[0]),
      .tag_gnt_i(tag_gnt), .tag_rvalid_i(tag_rvalid), .tag_valid_i(tag_valid), .tag_dirty_i(tag_dirty),
      .wb_req_o(wbr[0]), .wb_gnt_i(wb_gnt), .wb_done_i(wb_done), .perf_wb_cnt_o(perf0)
   );

   dcache_flush_seq #(.NumSets(4), .NumWays(2), .InvalidateOnFlush(1'b0)) dut1 (
      .clk_i(clk), .rst_ni(rst_ni), .flush_req_i(flush_req && (sel == 2'd1)),
      .flush_ack_o(ack[1]), .busy_o(busy[1]), .tag_req_o(treq[1]), .tag_we_o(twe[1]),
      .tag_idx_o(tidx1), .tag_way_o(tway[1:1]), .tag_wvalid_o(twv[1]), .tag_wdirty_o(twd[1]),
      .tag_gnt_i(tag_gnt), .tag_rvalid_i(tag_rvalid), .tag_valid_i(tag_valid), .tag_dirty_i(tag_dirty),
      .wb_req_o(wbr[1]), .wb_gnt_i(wb_gnt), .wb_done_i(wb_done), .perf_wb_cnt_o(perf1)
   );

   dcache_flush_seq #(.NumSets(2), .NumWays(2), .InvalidateOnFlush(1'b1)) dut2 (
      .clk_i(clk), .rst_ni(rst_ni), .flush_req_i(flush_req && (sel == 2'd2)),
      .flush_ack_o(ack[2]), .busy_o(busy[2]), .tag_req_o(treq[2]), .tag_we_o(twe[2]),
      .tag_idx_o(tidx2), .tag_way_o(tway[2:2]), .tag_wvalid_o(twv[2]), .tag_wdirty_o(twd[2]),
      .tag_gnt_i(tag_gnt), .tag_rvalid_i(tag_rvalid), .tag_valid_i(tag_valid), .tag_dirty_i(tag_dirty),
      .wb_req_o(wbr[2]), .wb_gnt_i(wb_gnt), .wb_done_i(wb_done), .perf_wb_cnt_o(perf2)
   );

   always_comb begin
      o_ack    = ack[sel];
      o_busy   = busy[sel];
      o_req    = treq[sel];
      o_we     = twe[sel];
      o_wvalid = twv[sel];
      o_wdirty = twd[sel];
      o_wb_req = wbr[sel];
      o_way    = tway[sel];
      case (sel)
         2'd0: begin
            o_idx  = tidx0;
            o_perf = perf0;
         end
         2'd1: begin
            o_idx  = tidx1;
            o_perf = perf1;
         end
         default: begin
            o_idx  = {1'b0, tidx2};
            o_perf = perf2;
         end
      endcase
   end

   // One flush pass on instance "sel": acts as tag array and miss unit, then scores the pass
   // against line-level expectations. status: 0 timeout, 1 completed, 2 reset during WBWAIT.
   task automatic run_pass(input string name, input int stall_pct, input int lmin, input int lmax,
                           input bit keep_req, input bit abort, output int lat, output int status);
      logic iv [8];
      logic id [8];
      int n, cyc, stalls, suml, wb_cd, rd_line, line, exp_lat, exp_perf;
      bit inv, done, rd_pend, p_req, p_gnt, p_wbr, p_wbg, p_we, p_wv, ev, ed;
      logic [1:0] p_idx;
      logic p_way;
      int ewb[$];
      int ewr[$];
      n = (sel == 2'd2) ? 4 : 8;
      inv = (sel != 2'd1);
      for (int l = 0; l < 8; l++) begin
         iv[l] = mv[l];
         id[l] = md[l];
      end
      lat = 0; status = 0; stalls = 0; suml = 0; wb_cd = 0; rd_line = 0;
      done = 0; rd_pend = 0; p_req = 0; p_gnt = 0; p_wbr = 0; p_wbg = 0;
      p_we = 0; p_wv = 0; p_idx = '0; p_way = 1'b0;
      rd_q.delete(); wr_q.delete(); wb_q.delete();
      cyc = 0;
      while (o_busy && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      flush_req = 1'b1;
      cyc = 0;
      while (!done && cyc < 3000) begin
         @(negedge clk);
         cyc++;
         if (!keep_req) flush_req = (cyc == 1) ? 1'b0 : 1'($urandom);
         tag_rvalid = rd_pend;
         if (rd_pend) begin
            tag_valid = mv[rd_line];
            tag_dirty = md[rd_line];
         end else begin
            tag_valid = 1'($urandom);
            tag_dirty = 1'($urandom);
         end
         rd_pend = 0;
         wb_done = 1'b0;
         if (wb_cd > 0) begin
            wb_cd--;
            if (wb_cd == 0) wb_done = 1'b1;
         end
         if (abort && wb_cd > 0) begin
            rst_ni = 1'b0;
            flush_req = 1'b0; tag_gnt = 1'b0; wb_gnt = 1'b0; tag_rvalid = 1'b0; wb_done = 1'b0;
            #1;
            status = 2;
            return;
         end
         if (p_req && !p_gnt) begin
            total++;
            if (o_req !== 1'b1 || o_idx !== p_idx || o_way !== p_way || o_we !== p_we || o_wvalid !== p_wv) begin
               bad++;
               $display("FAIL %s tag_hold cyc=%0d: got req=%b idx=%0d way=%0d we=%b wv=%b, need req=1 idx=%0d way=%0d we=%b wv=%b",
                        name, cyc, o_req, o_idx, o_way, o_we, o_wvalid, p_idx, p_way, p_we, p_wv);
            end
         end
         if (p_wbr && !p_wbg) begin
            total++;
            if (o_wb_req !== 1'b1 || o_idx !== p_idx || o_way !== p_way) begin
               bad++;
               $display("FAIL %s wb_hold cyc=%0d: got wb_req=%b idx=%0d way=%0d, need wb_req=1 idx=%0d way=%0d",
                        name, cyc, o_wb_req, o_idx, o_way, p_idx, p_way);
            end
         end
         if (o_ack === 1'b1) begin
            done = 1;
            lat = cyc;
            if (!keep_req) flush_req = 1'b0;
         end
         if (o_req === 1'b1) begin
            tag_gnt = ($urandom_range(0, 99) >= stall_pct);
            line = int'(o_idx) * 2 + int'(o_way);
            if (!tag_gnt) begin
               stalls++;
            end else if (o_we) begin
               wr_q.push_back(line * 4 + int'(o_wvalid) * 2 + int'(o_wdirty));
               mv[line] = o_wvalid;
               md[line] = o_wdirty;
            end else begin
               rd_q.push_back(line);
               rd_line = line;
               rd_pend = 1;
            end
         end else begin
            tag_gnt = 1'($urandom);
         end
         if (o_wb_req === 1'b1 && wb_cd == 0) begin
            wb_gnt = ($urandom_range(0, 99) >= stall_pct);
            if (!wb_gnt) begin
               stalls++;
            end else begin
               wb_q.push_back(int'(o_idx) * 2 + int'(o_way));
               wb_cd = $urandom_range(lmin, lmax);
               suml += wb_cd;
            end
         end else begin
            wb_gnt = 1'($urandom);
         end
         p_req = o_req; p_gnt = tag_gnt; p_idx = o_idx; p_way = o_way; p_we = o_we; p_wv = o_wvalid;
         p_wbr = o_wb_req; p_wbg = wb_gnt;
      end
      tag_gnt = 1'b0; wb_gnt = 1'b0; tag_rvalid = 1'b0; wb_done = 1'b0;
      total++;
      if (!done) begin
         bad++;
         $display("FAIL %s ack_timeout: got no ack in %0d cycles, need ack", name, cyc);
         flush_req = 1'b0;
         return;
      end
      status = 1;
      @(negedge clk);
      if (o_ack !== 1'b0 || o_busy !== 1'b0) begin
         bad++;
         $display("FAIL %s ack_pulse: got ack=%b busy=%b after ack, need ack=0 busy=0", name, o_ack, o_busy);
      end

      // expectations from the line contents seen at the start of the pass
      exp_lat = 1 + stalls + suml;
      for (int l = 0; l < n; l++) begin
         if (!iv[l]) begin
            exp_lat += 2;
         end else if (id[l]) begin
            exp_lat += 4;
            ewb.push_back(l);
            ewr.push_back(l * 4 + (inv ? 0 : 2));
         end else if (inv) begin
            exp_lat += 3;
            ewr.push_back(l * 4);
         end else begin
            exp_lat += 2;
         end
      end
      total++;
      if (rd_q.size() != n) begin
         bad++;
         $display("FAIL %s read_count: got %0d, need %0d", name, rd_q.size(), n);
      end
      for (int i = 0; i < rd_q.size() && i < n; i++) begin
         total++;
         if (rd_q[i] != i) begin
            bad++;
            $display("FAIL %s read_order[%0d]: got line %0d, need line %0d", name, i, rd_q[i], i);
         end
      end
      total++;
      if (wb_q.size() != ewb.size()) begin
         bad++;
         $display("FAIL %s wb_count: got %0d, need %0d", name, wb_q.size(), ewb.size());
      end
      for (int i = 0; i < wb_q.size() && i < ewb.size(); i++) begin
         total++;
         if (wb_q[i] != ewb[i]) begin
            bad++;
            $display("FAIL %s wb_line[%0d]: got %0d, need %0d", name, i, wb_q[i], ewb[i]);
         end
      end
      total++;
      if (wr_q.size() != ewr.size()) begin
         bad++;
         $display("FAIL %s write_count: got %0d, need %0d", name, wr_q.size(), ewr.size());
      end
      for (int i = 0; i < wr_q.size() && i < ewr.size(); i++) begin
         total++;
         if (wr_q[i] != ewr[i]) begin
            bad++;
            $display("FAIL %s write[%0d]: got line=%0d wv=%0d wd=%0d, need line=%0d wv=%0d wd=%0d", name, i,
                     wr_q[i] / 4, (wr_q[i] / 2) % 2, wr_q[i] % 2, ewr[i] / 4, (ewr[i] / 2) % 2, ewr[i] % 2);
         end
      end
      for (int l = 0; l < n; l++) begin
         ev = (iv[l] && (id[l] || inv)) ? !inv : iv[l];
         ed = (iv[l] && (id[l] || inv)) ? 1'b0 : id[l];
         total++;
         if (mv[l] !== ev || md[l] !== ed) begin
            bad++;
            $display("FAIL %s line_state[%0d]: got v=%b d=%b, need v=%b d=%b", name, l, mv[l], md[l], ev, ed);
         end
      end
      total++;
      if (lat != exp_lat) begin
         bad++;
         $display("FAIL %s ack_latency: got %0d cycles, need %0d (stalls=%0d)", name, lat, exp_lat, stalls);
      end
`ifdef DCACHE_FLUSH_PERF_EN
      exp_perf = ewb.size();
`else
      exp_perf = 0;
`endif
      total++;
      if (int'(o_perf) != exp_perf) begin
         bad++;
         $display("FAIL %s perf_wb_cnt: got %0d, need %0d", name, o_perf, exp_perf);
      end
      $display("pass %s: inst=%0d lat=%0d reads=%0d wbs=%0d writes=%0d stalls=%0d", name, sel, lat,
               rd_q.size(), wb_q.size(), wr_q.size(), stalls);
   endtask

   task automatic load_mem(input logic [7:0] v, input logic [7:0] d);
      for (int l = 0; l < 8; l++) begin
         mv[l] = v[l];
         md[l] = d[l];
      end
   endtask

   task automatic test_reset();
      #2 rst_ni = 1'b0;
      repeat (3) @(negedge clk);
      for (int s = 0; s < 3; s++) begin
         sel = 2'(s);
         #1;
         total++;
         if ({o_ack, o_busy, o_req, o_we, o_wvalid, o_wdirty, o_wb_req, o_idx, o_way, o_perf} !== '0) begin
            bad++;
            $display("FAIL reset_outputs inst=%0d: got ack=%b busy=%b req=%b we=%b wv=%b wd=%b wb=%b idx=%0d way=%0d perf=%0d, need all 0",
                     s, o_ack, o_busy, o_req, o_we, o_wvalid, o_wdirty, o_wb_req, o_idx, o_way, o_perf);
         end
      end
      sel = 2'd0;
      @(negedge clk);
      rst_ni = 1'b1;
      $display("reset: outputs checked on three instances");
   endtask

   task automatic test_empty();
      int lat, st;
      sel = 2'd0;
      load_mem(8'h00, 8'($urandom));
      run_pass("empty", 0, 1, 1, 1'b0, 1'b0, lat, st);
      total++;
      if (lat != 17) begin
         bad++;
         $display("FAIL empty_ack_cycle: got %0d, need 17", lat);
      end
   endtask

   task automatic test_dirty_line();
      int lat, st;
      for (int s = 0; s < 2; s++) begin
         sel = 2'(s);
         load_mem(8'b0010_0000, 8'b0010_0000);
         run_pass(s == 0 ? "dirty21_inv" : "dirty21_clean", 0, 5, 5, 1'b0, 1'b0, lat, st);
      end
   endtask

   task automatic test_stall();
      int lat, st;
      for (int k = 0; k < 3; k++) begin
         sel = 2'(k % 2);
         load_mem(8'($urandom), 8'($urandom));
         run_pass("stall", 45, 1, 4, 1'b0, 1'b0, lat, st);
      end
   endtask

   task automatic test_reset_mid();
      int lat, st;
      sel = 2'd0;
      load_mem(8'hFF, 8'h0F);
      run_pass("abort", 0, 3, 3, 1'b0, 1'b1, lat, st);
      total++;
      if (st != 2) begin
         bad++;
         $display("FAIL abort_reached_wbwait: got status %0d, need 2", st);
      end
      total++;
      if ({o_ack, o_busy, o_req, o_we, o_wvalid, o_wdirty, o_wb_req, o_idx, o_way, o_perf} !== '0) begin
         bad++;
         $display("FAIL abort_outputs: got ack=%b busy=%b req=%b we=%b wb=%b idx=%0d way=%0d perf=%0d, need all 0",
                  o_ack, o_busy, o_req, o_we, o_wb_req, o_idx, o_way, o_perf);
      end
      @(negedge clk);
      rst_ni = 1'b1;
      run_pass("after_abort", 10, 1, 3, 1'b0, 1'b0, lat, st);
   endtask

   task automatic test_back_to_back();
      int lat, st, picked, l;
      logic [7:0] v, d;
      for (int s = 0; s < 2; s++) begin
         sel = 2'(s);
         v = 8'($urandom);
         d = 8'h00;
         picked = 0;
         while (picked < 3) begin
            l = $urandom_range(0, 7);
            if (!d[l]) begin
               d[l] = 1'b1;
               v[l] = 1'b1;
               picked++;
            end
         end
         load_mem(v, d);
         run_pass("b2b_first", 0, 1, 3, 1'b1, 1'b0, lat, st);
         run_pass("b2b_second", 0, 1, 3, 1'b0, 1'b0, lat, st);
      end
   endtask

   task automatic test_small();
      int lat, st;
      sel = 2'd2;
      load_mem(8'h0F, 8'h00);
      run_pass("small_2x2", 0, 1, 1, 1'b0, 1'b0, lat, st);
      total++;
      if (lat != 13) begin
         bad++;
         $display("FAIL small_ack_cycle: got %0d, need 13", lat);
      end
   endtask

   task automatic test_random();
      int lat, st;
      for (int k = 0; k < 8; k++) begin
         sel = 2'($urandom_range(0, 2));
         load_mem(8'($urandom), 8'($urandom));
         run_pass("random", $urandom_range(0, 30), 1, 6, 1'b0, 1'b0, lat, st);
      end
   endtask

   initial begin
      load_mem(8'h00, 8'h00);
      test_reset();
      test_empty();
      test_dirty_line();
      test_stall();
      test_reset_mid();
      test_back_to_back();
      test_small();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
